// File: rtl/mem_read_control.sv
// Streams completed events from the event-size/L1A/data memories as framed
// 16-bit words: header, size, data words, XOR checksum trailer.
module mem_read_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        readout_en,
  input  logic [7:0]  es_wr_addr,
  input  logic [10:0] es_rd_data,
  input  logic [13:0] L1A_rd_data,
  input  logic [15:0] data_rd_data,
  output logic [7:0]  es_rd_addr,
  output logic [7:0]  L1A_rd_addr,
  output logic [15:0] data_rd_addr,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        dout_sop,
  output logic        dout_eop,
  input  logic        dout_ready,
  output logic [7:0]  evt_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, HDR, SIZE, DATA, TRL} state_t;

  state_t      state, state_n;
  logic [7:0]  rd_ptr, rd_ptr_n, es_rd_addr_n, evt_cnt_n;
  logic [10:0] es_q, es_q_n, data_left, data_left_n, reads_left, reads_left_n, reads_rem;
  logic [15:0] csum, csum_n, csum_acc, head_word;
  logic [15:0] buf0, buf1, buf0_n, buf1_n, data_rd_addr_n, dout_n;
  logic [1:0]  occ, occ_n;
  logic        inflight, issue, take_data, push, pop_buf, avail, pending, accepted;
  logic        dout_valid_n, dout_sop_n, dout_eop_n, busy_n;

  assign L1A_rd_addr = es_rd_addr;

  always_comb begin
    pending   = (rd_ptr != es_wr_addr);
    accepted  = dout_valid && dout_ready;
    avail     = (occ != 2'd0) || inflight;
    head_word = (occ != 2'd0) ? buf0 : data_rd_data;
    csum_acc  = csum ^ (accepted ? dout : '0);

    // Reads may start in LATCH straight off the memory output so the first
    // data word is already buffered by the time W1 is accepted.
    reads_rem = (state == LATCH) ? es_rd_data : reads_left;
    issue = (state inside {LATCH, HDR, SIZE, DATA}) && (reads_rem != '0) &&
            (({1'b0, occ} + {2'b0, inflight}) < 3'd2);
    reads_left_n   = reads_rem - {10'b0, issue};
    data_rd_addr_n = data_rd_addr + {15'b0, issue};

    state_n      = state;
    rd_ptr_n     = rd_ptr;
    es_rd_addr_n = es_rd_addr;
    evt_cnt_n    = evt_cnt;
    es_q_n       = es_q;
    data_left_n  = data_left;
    csum_n       = csum;
    dout_n       = dout;
    dout_valid_n = dout_valid;
    dout_sop_n   = dout_sop;
    dout_eop_n   = dout_eop;
    busy_n       = busy;
    take_data    = 1'b0;

    case (state)
      IDLE: begin
        if (pending && readout_en) begin
          es_rd_addr_n = rd_ptr + 8'd1;
          busy_n       = 1'b1;
          state_n      = FETCH;
        end
      end
      FETCH: state_n = LATCH;
      LATCH: begin
        es_q_n       = es_rd_data;
        csum_n       = '0;
        dout_n       = {2'b11, L1A_rd_data};
        dout_valid_n = 1'b1;
        dout_sop_n   = 1'b1;
        dout_eop_n   = 1'b0;
        state_n      = HDR;
      end
      HDR: begin
        if (dout_ready) begin
          dout_n     = {5'b0, es_q};
          dout_sop_n = 1'b0;
          state_n    = SIZE;
        end
      end
      SIZE: begin
        if (dout_ready) begin
          if (es_q == '0) begin
            dout_n     = csum;
            dout_eop_n = 1'b1;
            state_n    = TRL;
          end else begin
            state_n     = DATA;
            data_left_n = es_q;
            if (avail) begin
              take_data   = 1'b1;
              dout_n      = head_word;
              data_left_n = es_q - 11'd1;
            end else begin
              dout_valid_n = 1'b0;
            end
          end
        end
      end
      DATA: begin
        if (!dout_valid || dout_ready) begin
          csum_n = csum_acc;
          if (data_left != '0) begin
            if (avail) begin
              take_data    = 1'b1;
              dout_n       = head_word;
              dout_valid_n = 1'b1;
              data_left_n  = data_left - 11'd1;
            end else begin
              dout_valid_n = 1'b0;
            end
          end else begin
            dout_n       = csum_acc;
            dout_valid_n = 1'b1;
            dout_eop_n   = 1'b1;
            state_n      = TRL;
          end
        end
      end
      TRL: begin
        if (dout_ready) begin
          dout_valid_n = 1'b0;
          dout_eop_n   = 1'b0;
          rd_ptr_n     = rd_ptr + 8'd1;
          evt_cnt_n    = evt_cnt + 8'd1;
          busy_n       = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Skid buffer: a returning word bypasses straight into dout when the
  // buffer is empty and the output slot is taking data this cycle.
  always_comb begin
    pop_buf = take_data && (occ != 2'd0);
    push    = inflight && !(take_data && (occ == 2'd0));
    buf0_n  = buf0;
    buf1_n  = buf1;
    occ_n   = occ;
    if (pop_buf) begin
      buf0_n = buf1;
      occ_n  = occ - 2'd1;
    end
    if (push) begin
      if (occ_n == 2'd0) buf0_n = data_rd_data;
      else               buf1_n = data_rd_data;
      occ_n = occ_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      es_rd_addr   <= '0;
      data_rd_addr <= '0;
      evt_cnt      <= '0;
      es_q         <= '0;
      data_left    <= '0;
      reads_left   <= '0;
      csum         <= '0;
      buf0         <= '0;
      buf1         <= '0;
      occ          <= '0;
      inflight     <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      dout_sop     <= 1'b0;
      dout_eop     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      rd_ptr       <= rd_ptr_n;
      es_rd_addr   <= es_rd_addr_n;
      data_rd_addr <= data_rd_addr_n;
      evt_cnt      <= evt_cnt_n;
      es_q         <= es_q_n;
      data_left    <= data_left_n;
      reads_left   <= reads_left_n;
      csum         <= csum_n;
      buf0         <= buf0_n;
      buf1         <= buf1_n;
      occ          <= occ_n;
      inflight     <= issue;
      dout         <= dout_n;
      dout_valid   <= dout_valid_n;
      dout_sop     <= dout_sop_n;
      dout_eop     <= dout_eop_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_read_control.sv
// Bench for mem_read_control: behavioural event memories, a table of events
// with hand-derived frames, and a scoreboard of expected output words.
module tb_mem_read_control;

  logic        clk, reset, readout_en, dout_ready;
  logic [7:0]  es_wr_addr, es_rd_addr, L1A_rd_addr, evt_cnt;
  logic [10:0] es_rd_data;
  logic [13:0] L1A_rd_data;
  logic [15:0] data_rd_data, data_rd_addr, dout;
  logic        dout_valid, dout_sop, dout_eop, busy;

  mem_read_control dut (
    .clk(clk), .reset(reset), .readout_en(readout_en), .es_wr_addr(es_wr_addr),
    .es_rd_data(es_rd_data), .L1A_rd_data(L1A_rd_data), .data_rd_data(data_rd_data),
    .es_rd_addr(es_rd_addr), .L1A_rd_addr(L1A_rd_addr), .data_rd_addr(data_rd_addr),
    .dout(dout), .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_ready(dout_ready), .evt_cnt(evt_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] es_mem   [256];
  logic [13:0] l1a_mem  [256];
  logic [15:0] data_mem [65536];

  always @(posedge clk) begin
    es_rd_data   <= es_mem[es_rd_addr];
    L1A_rd_data  <= l1a_mem[L1A_rd_addr];
    data_rd_data <= data_mem[data_rd_addr];
  end

  typedef struct packed {logic [15:0] w; logic sop; logic eop;} word_t;
  typedef struct packed {
    logic [10:0]      es;
    logic [13:0]      l1a;
    logic [3:0][15:0] d;
    logic [15:0]      w0, w1, trl;
  } vec_t;

  vec_t  tbl [5];
  word_t exp_q [$];
  word_t prev_w;
  int    n_vec, n_fail, cyc, pcnt, last_eop;
  logic  prev_stall, in_frame, have_eop, contig, gap_chk, bp_mode;
  logic [7:0]  tb_ptr, exp_evt;
  logic [15:0] dwp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: observe outputs at the falling edge, return just after the rising edge.
  task automatic step();
    word_t a, e;
    @(negedge clk);
    if (reset) begin
      prev_stall = 1'b0;
      in_frame   = 1'b0;
    end else begin
      a = {dout, dout_sop, dout_eop};
      if (!dout_valid) begin
        n_vec++;
        if (dout_sop || dout_eop) begin
          n_fail++;
          $display("FAIL sideband: sop=%0d eop=%0d while invalid, expected 0/0", dout_sop, dout_eop);
        end
      end
      if (prev_stall) begin
        n_vec++;
        if (!dout_valid || a != prev_w) begin
          n_fail++;
          $display("FAIL hold: got v%0d %h/%0d/%0d expected v1 %h/%0d/%0d", dout_valid,
                   a.w, a.sop, a.eop, prev_w.w, prev_w.sop, prev_w.eop);
        end
      end
      if (contig && in_frame) begin
        n_vec++;
        if (!dout_valid) begin
          n_fail++;
          $display("FAIL contig: valid=0 inside frame at cycle %0d, expected 1", cyc);
        end
      end
      if (dout_valid && dout_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL word: got %h sop%0d eop%0d, expected no word", a.w, a.sop, a.eop);
        end else begin
          e = exp_q.pop_front();
          if (a != e) begin
            n_fail++;
            $display("FAIL word: got %h sop%0d eop%0d, expected %h sop%0d eop%0d",
                     a.w, a.sop, a.eop, e.w, e.sop, e.eop);
          end
        end
        if (dout_sop) begin
          if (gap_chk && have_eop) begin
            n_vec++;
            if (cyc - last_eop != 4) begin
              n_fail++;
              $display("FAIL gap: eop-to-sop %0d cycles, expected 4", cyc - last_eop);
            end
          end
          in_frame = 1'b1;
        end
        if (dout_eop) begin
          in_frame = 1'b0;
          last_eop = cyc;
          have_eop = 1'b1;
        end
      end
      prev_stall = dout_valid && !dout_ready;
      prev_w     = a;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (bp_mode) begin
      dout_ready = (pcnt % 3 == 0);
      pcnt++;
    end
  endtask

  task automatic push_exp(input logic [15:0] w, input logic sop, input logic eop);
    exp_q.push_back({w, sop, eop});
  endtask

  task automatic put_data(input logic [15:0] w);
    data_mem[dwp] = w;
    dwp = dwp + 16'd1;
  endtask

  task automatic commit_evt(input logic [10:0] es, input logic [13:0] l1a);
    logic [7:0] wa;
    wa = tb_ptr + 8'd1;
    es_mem[wa]  = es;
    l1a_mem[wa] = l1a;
    tb_ptr      = wa;
    es_wr_addr  = wa;
    exp_evt     = exp_evt + 8'd1;
  endtask

  task automatic apply_vec(input int i);
    push_exp(tbl[i].w0, 1'b1, 1'b0);
    push_exp(tbl[i].w1, 1'b0, 1'b0);
    for (int j = 0; j < int'(tbl[i].es); j++) begin
      put_data(tbl[i].d[j]);
      push_exp(tbl[i].d[j], 1'b0, 1'b0);
    end
    push_exp(tbl[i].trl, 1'b0, 1'b1);
    commit_evt(tbl[i].es, tbl[i].l1a);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL %s: timeout, %0d words outstanding, expected 0", nm, exp_q.size());
    end
    step();
    step();
  endtask

  initial begin
    int n, rem, esf;
    logic [15:0] w, x, d0;
    logic [13:0] l1a;

    tbl[0] = '{11'd3, 14'h0123, {16'h0000, 16'h6000, 16'h8002, 16'h8001}, 16'hC123, 16'h0003, 16'h6003};
    tbl[1] = '{11'd0, 14'h3FFF, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hFFFF, 16'h0000, 16'h0000};
    tbl[2] = '{11'd1, 14'h0000, {16'h0000, 16'h0000, 16'h0000, 16'hA5A5}, 16'hC000, 16'h0001, 16'hA5A5};
    tbl[3] = '{11'd4, 14'h1234, {16'h0008, 16'h0004, 16'h0002, 16'h0001}, 16'hD234, 16'h0004, 16'h000F};
    tbl[4] = '{11'd2, 14'h2AAA, {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF}, 16'hEAAA, 16'h0002, 16'h0000};

    n_vec = 0; n_fail = 0; cyc = 0; pcnt = 0; last_eop = 0;
    prev_stall = 0; in_frame = 0; have_eop = 0; contig = 0; gap_chk = 0; bp_mode = 0;
    tb_ptr = 0; exp_evt = 0; dwp = 0; prev_w = '0;
    reset = 1; readout_en = 0; es_wr_addr = 0; dout_ready = 1;
    repeat (3) step();

    check("rst_dout", dout, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_sop", dout_sop, 0);
    check("rst_eop", dout_eop, 0);
    check("rst_es_addr", es_rd_addr, 0);
    check("rst_l1a_addr", L1A_rd_addr, 0);
    check("rst_data_addr", data_rd_addr, 0);
    check("rst_evt_cnt", evt_cnt, 0);
    check("rst_busy", busy, 0);
    reset = 0;
    step();

    // Single event with latency and contiguity checks
    readout_en = 1;
    contig = 1;
    apply_vec(0);
    step();
    check("lat_busy", busy, 1);
    check("lat_valid1", dout_valid, 0);
    step();
    check("lat_valid2", dout_valid, 0);
    step();
    check("lat_valid3", dout_valid, 1);
    check("lat_w0", dout, 16'hC123);
    check("lat_es_addr", es_rd_addr, 8'h01);
    wait_drain("single", 100);
    check("single_evt_cnt", evt_cnt, 1);
    check("single_data_addr", data_rd_addr, 3);

    // Back-to-back table events, ready held high
    gap_chk = 1; have_eop = 0;
    for (int i = 1; i < 5; i++) apply_vec(i);
    wait_drain("batch", 300);
    gap_chk = 0;
    check("batch_evt_cnt", evt_cnt, exp_evt);
    check("batch_data_addr", data_rd_addr, dwp);

    // Empty event issues no data reads
    d0 = data_rd_addr;
    apply_vec(1);
    wait_drain("empty", 100);
    check("empty_data_addr", data_rd_addr, d0);

    // Backpressure 1,0,0 pattern
    contig = 0; bp_mode = 1; pcnt = 0;
    apply_vec(0);
    wait_drain("backpressure", 300);
    bp_mode = 0; dout_ready = 1;
    check("bp_evt_cnt", evt_cnt, exp_evt);

    // readout_en gating: one pulse, exactly one frame
    readout_en = 0;
    apply_vec(2);
    apply_vec(4);
    repeat (20) step();
    check("gate_busy", busy, 0);
    check("gate_valid", dout_valid, 0);
    readout_en = 1;
    step();
    readout_en = 0;
    n = 0;
    while ((exp_q.size() != 5 || busy) && n < 200) begin step(); n++; end
    repeat (20) step();
    check("gate_left", exp_q.size(), 5);
    check("gate_busy2", busy, 0);
    check("gate_evt_cnt", evt_cnt, exp_evt - 8'd1);
    readout_en = 1;
    wait_drain("gate_rest", 100);
    check("gate_evt_cnt2", evt_cnt, exp_evt);

    // Reset during DATA of a 10-word event
    push_exp({2'b11, 14'h0AAA}, 1'b1, 1'b0);
    push_exp(16'd10, 1'b0, 1'b0);
    x = 0;
    for (int j = 0; j < 10; j++) begin
      w = 16'($urandom);
      put_data(w);
      push_exp(w, 1'b0, 1'b0);
      x ^= w;
    end
    push_exp(x, 1'b0, 1'b1);
    commit_evt(11'd10, 14'h0AAA);
    n = 0;
    while (!(dout_valid && dout_sop) && n < 50) begin step(); n++; end
    check("rst_mid_sop_seen", dout_valid && dout_sop, 1);
    repeat (4) step();
    reset = 1;
    step();
    check("rstm_dout", dout, 0);
    check("rstm_valid", dout_valid, 0);
    check("rstm_eop", dout_eop, 0);
    check("rstm_es_addr", es_rd_addr, 0);
    check("rstm_data_addr", data_rd_addr, 0);
    check("rstm_evt_cnt", evt_cnt, 0);
    check("rstm_busy", busy, 0);
    exp_q.delete();
    tb_ptr = 0; dwp = 0; exp_evt = 0; es_wr_addr = 0;
    step();
    reset = 0;
    step();
    apply_vec(3);
    wait_drain("after_reset", 100);
    check("ar_evt_cnt", evt_cnt, 1);
    check("ar_data_addr", data_rd_addr, 4);

    // Fill until rd_ptr reaches FF and the data pointer reaches FFFE
    contig = 1;
    rem = 32'hFFFE - int'(dwp);
    while (tb_ptr != 8'hFF) begin
      esf = (rem > 2047) ? 2047 : rem;
      l1a = 14'($urandom);
      push_exp({2'b11, l1a}, 1'b1, 1'b0);
      push_exp({5'b0, 11'(esf)}, 1'b0, 1'b0);
      x = 0;
      for (int j = 0; j < esf; j++) begin
        w = 16'($urandom);
        put_data(w);
        push_exp(w, 1'b0, 1'b0);
        x ^= w;
      end
      push_exp(x, 1'b0, 1'b1);
      commit_evt(11'(esf), l1a);
      rem -= esf;
    end
    wait_drain("bulk", 75000);
    check("bulk_data_addr", data_rd_addr, 16'hFFFE);
    check("bulk_es_addr", es_rd_addr, 8'hFF);

    // Wrap event: es addr 00, data FFFE..0001
    push_exp(16'hC055, 1'b1, 1'b0);
    push_exp(16'h0004, 1'b0, 1'b0);
    push_exp(16'h1111, 1'b0, 1'b0);
    push_exp(16'h2222, 1'b0, 1'b0);
    push_exp(16'h4444, 1'b0, 1'b0);
    push_exp(16'h8888, 1'b0, 1'b0);
    push_exp(16'hFFFF, 1'b0, 1'b1);
    put_data(16'h1111); put_data(16'h2222); put_data(16'h4444); put_data(16'h8888);
    commit_evt(11'd4, 14'h0055);
    wait_drain("wrap", 100);
    check("wrap_es_addr", es_rd_addr, 8'h00);
    check("wrap_l1a_addr", L1A_rd_addr, 8'h00);
    check("wrap_data_addr", data_rd_addr, 16'h0002);
    check("wrap_evt_cnt", evt_cnt, exp_evt);
    repeat (10) step();
    check("wrap_idle_busy", busy, 0);
    check("wrap_idle_valid", dout_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_read_control.md
# mem_read_control

Reads completed events out of the three event memories (data, event-size, L1A) that the front-end write controller fills, and streams each event as a framed 16-bit word sequence toward the downstream link or transmitter. Sits between the dual-port event memories and the output serializer. Walks the event-size/L1A memories with its own read pointer, fetches the matching data words, and appends an XOR checksum. Honours downstream backpressure without dropping or duplicating words.

## Interface
- No parameters. Widths are fixed to match the write side: data address 16, es/L1A address 8, event size 11, L1A 14.
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- readout_en  in  1  permits starting a new frame.
- es_wr_addr  in  8  write-side event-size pointer; the address of the last written event.
- es_rd_data  in  11  event-size memory read data; 1-cycle latency.
- L1A_rd_data  in  14  L1A memory read data; 1-cycle latency.
- data_rd_data  in  16  data memory read data; 1-cycle latency.
- es_rd_addr  out  8  event-size memory read address.
- L1A_rd_addr  out  8  L1A memory read address; always equal to es_rd_addr.
- data_rd_addr  out  16  data memory read address.
- dout  out  16  output word.
- dout_valid  out  1  dout holds a valid word.
- dout_sop  out  1  first word of a frame; qualified by dout_valid.
- dout_eop  out  1  last word of a frame; qualified by dout_valid.
- dout_ready  in  1  downstream accepts the word when dout_valid and dout_ready are both high.
- evt_cnt  out  8  number of frames completed since reset; wraps modulo 256.
- busy  out  1  high from frame start through acceptance of the eop word.

## Operation
- Frame format, in order:
  - W0 = {2'b11, L1A[13:0]}, with sop=1.
  - W1 = {5'b0, es[10:0]}.
  - es data words, read in sequence from data memory.
  - Trailer = XOR of all data words in the frame, with eop=1. An empty frame has trailer 16'h0000.
- Pointers:
  - rd_ptr (8b) resets to 0.
  - An event is pending when rd_ptr != es_wr_addr.
  - The event is read at address rd_ptr+1, because the writer pre-increments its pointer.
  - data_rd_addr resets to 16'h0000; the writer's first data word lands at address 0.
  - Both pointers wrap naturally: 8'hFF->8'h00 and 16'hFFFF->16'h0000.
- FSM states:
  - IDLE: when pending && readout_en, drive es/L1A_rd_addr = rd_ptr+1 and go to FETCH.
  - FETCH: wait out the memory latency.
  - LATCH: register es and L1A, clear the checksum, go to HDR.
  - HDR: present W0 and hold it until accepted, then go to SIZE.
  - SIZE: present W1 and hold it until accepted. Go to DATA if es>0, otherwise go to TRL.
  - DATA: stream es words, each data word XOR'd into the checksum on acceptance. When the last data word is accepted, go to TRL.
  - TRL: present the trailer and hold it until accepted. On acceptance: rd_ptr+1, evt_cnt+1, back to IDLE.
- Data fetch is pipelined through a 2-entry skid buffer:
  - A data read is issued only if buffer occupancy plus in-flight reads is less than 2.
  - data_rd_addr increments once per issued read; exactly es reads are issued per frame.
- readout_en only gates the IDLE->FETCH transition. Deasserting it mid-frame does not stop the current frame.
- The frame's es value is whatever the memory holds. The block does not check es against the data write pointer; the writer guarantees data is written before es.

## Timing
- Reset values:
  - dout=0, dout_valid=0, dout_sop=0, dout_eop=0.
  - es_rd_addr=0, L1A_rd_addr=0, data_rd_addr=0.
  - evt_cnt=0, busy=0.
  - FSM=IDLE, skid buffer empty, checksum=0.
- Reset mid-frame abandons the frame: no eop is emitted and the pointers return to 0.
- All outputs are registered.
- Latency: W0 dout_valid rises exactly 3 cycles after the IDLE cycle in which pending && readout_en is true.
- busy rises 1 cycle after that IDLE cycle.
- Holding rules:
  - While dout_valid=1 and dout_ready=0, the values of dout, dout_sop and dout_eop are held unchanged.
  - dout_valid never drops before the word is accepted.
- Throughput with dout_ready held at 1:
  - One word per cycle from W0 through the trailer, with no bubbles.
  - Frame length is es+3 cycles.
  - The gap between two back-to-back frames' eop and sop is 3 idle cycles.
- Sideband qualification: sop and eop are 0 whenever dout_valid=0. For es=0, sop and eop never assert on the same word.
- If pending becomes true in the same cycle a frame's trailer is accepted, the next frame starts from IDLE on the following cycle.

## Test plan
- Single event at es addr 1: es=3, L1A=14'h0123, data 8001/8002/6000 at 0..2 -> dout C123(sop), 0003, 8001, 8002, 6000, 6003(eop), contiguous. Afterwards evt_cnt=1, data_rd_addr=3.
- Backpressure: same event with dout_ready toggling 1,0,0,1,... -> identical word sequence, no duplicates or drops, and dout stable while stalled.
- Empty event: es=0, L1A=0x3FFF -> FFFF(sop), 0000, 0000(eop). No data reads issued; data_rd_addr unchanged.
- Pointer wrap: rd_ptr=8'hFF, es_wr_addr=8'h00, data start 16'hFFFE, es=4 -> reads es address 8'h00, then data addresses FFFE, FFFF, 0000, 0001. rd_ptr ends at 0.
- readout_en=0 with 2 pending events -> no output. Raise readout_en for 1 cycle -> exactly one full frame is emitted, and the second event waits.
- Reset asserted during the DATA state of a 10-word event -> the next cycle has all outputs 0. After release and a re-write starting at es addr 1, the first frame is correct.
